// File: rtl/dma_cmd_pkg.sv
// Shared types and constants for the DMA command loader: one-hot state
// encoding, register field window and loader error codes.
package dma_cmd_pkg;

  localparam int FIELD_LO = 1;
  localparam int FIELD_HI = 30;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_COLLECT = 3'b010,
    S_COMMIT  = 3'b100
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVF   = 2'b01;
  localparam logic [1:0] ERR_UNF   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

endpackage

// File: rtl/dma_lsb_enc.sv
// Lowest-set-bit encoder: position of the least significant 1 in mask plus an
// any-set flag. Purely combinational.
module dma_lsb_enc #(
  parameter int W = 30
) (
  input  logic [W-1:0] mask,
  output logic [4:0]   idx,
  output logic         any
);

  // Scan downward so the lowest set bit is the last one assigned.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 5'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_cmd_loader.sv
// Buffers descriptor words into a shadow bank keyed by the link header field
// mask, then commits them to the channel register file as ordered single writes.
module dma_cmd_loader #(
  parameter int FIELD_LO = dma_cmd_pkg::FIELD_LO,
  parameter int FIELD_HI = dma_cmd_pkg::FIELD_HI
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        hdr_valid,
  input  logic [31:0] link_header,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  input  logic        cmd_done,
  input  logic        cmd_error,
  input  logic        err_clr,
  output logic        reg_wr_en,
  input  logic        reg_wr_ready,
  output logic [4:0]  reg_wr_idx,
  output logic [31:0] reg_wr_data,
  output logic        load_done,
  output logic        busy,
  output logic        ldr_err,
  output logic [1:0]  ldr_err_code
);
  import dma_cmd_pkg::*;

  localparam int         NF      = FIELD_HI - FIELD_LO + 1;
  localparam logic [4:0] IDX_OFS = 5'(FIELD_LO);

  state_t          state_q, state_d;
  logic [NF-1:0]   pending_q, pending_d;
  logic [NF-1:0]   filled_q, filled_d;
  logic [31:0]     shadow_q [NF];
  logic            load_done_q, load_done_d;
  logic            ldr_err_q;
  logic [1:0]      err_code_q;
  logic [NF-1:0]   hdr_mask;
  logic [4:0]      p_pos, f_pos;
  logic            p_any, f_any;
  logic            shadow_we;
  logic            err_set;
  logic [1:0]      err_new;
  logic            unused_hdr;

  assign hdr_mask   = link_header[FIELD_HI:FIELD_LO];
  assign unused_hdr = ^{link_header, f_any};

  dma_lsb_enc #(.W(NF)) u_pend_enc (.mask(pending_q), .idx(p_pos), .any(p_any));
  dma_lsb_enc #(.W(NF)) u_fill_enc (.mask(filled_q),  .idx(f_pos), .any(f_any));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    filled_d    = filled_q;
    load_done_d = 1'b0;
    shadow_we   = 1'b0;
    err_set     = 1'b0;
    err_new     = ERR_NONE;
    case (state_q)
      S_IDLE: begin
        if (hdr_valid && !cmd_error) begin
          pending_d = hdr_mask;
          filled_d  = '0;
          if (|hdr_mask) state_d = S_COLLECT;
          else           load_done_d = 1'b1;
        end
      end
      S_COLLECT: begin
        if (cmd_error) begin
          err_set = 1'b1;
          err_new = ERR_ABORT;
        end else if (hdr_valid) begin
          pending_d = hdr_mask;
          filled_d  = '0;
          if (!(|hdr_mask)) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end
        end else begin
          if (word_valid) begin
            if (p_any) begin
              shadow_we          = 1'b1;
              pending_d[p_pos]   = 1'b0;
              filled_d[p_pos]    = 1'b1;
            end else begin
              err_set = 1'b1;
              err_new = ERR_OVF;
            end
          end
          // Completion is judged after the same-cycle word has been applied.
          if (cmd_done && !err_set) begin
            if (|pending_d) begin
              err_set = 1'b1;
              err_new = ERR_UNF;
            end else begin
              state_d = S_COMMIT;
            end
          end
        end
      end
      S_COMMIT: begin
        if (cmd_error) begin
          err_set = 1'b1;
          err_new = ERR_ABORT;
        end else if (reg_wr_ready) begin
          filled_d[f_pos] = 1'b0;
          if (filled_d == '0) begin
            state_d     = S_IDLE;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (err_set) begin
      state_d   = S_IDLE;
      pending_d = '0;
      filled_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      filled_q    <= '0;
      load_done_q <= 1'b0;
      ldr_err_q   <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      filled_q    <= filled_d;
      load_done_q <= load_done_d;
      // First error code sticks; a new error alongside err_clr replaces it.
      if (err_set && (!ldr_err_q || err_clr)) begin
        ldr_err_q  <= 1'b1;
        err_code_q <= err_new;
      end else if (err_clr) begin
        ldr_err_q  <= 1'b0;
        err_code_q <= ERR_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[p_pos] <= word_data;
  end

  assign busy         = (state_q != S_IDLE);
  assign reg_wr_en    = (state_q == S_COMMIT);
  assign reg_wr_idx   = reg_wr_en ? (f_pos + IDX_OFS) : '0;
  assign reg_wr_data  = reg_wr_en ? shadow_q[f_pos] : '0;
  assign load_done    = load_done_q;
  assign ldr_err      = ldr_err_q;
  assign ldr_err_code = err_code_q;

endmodule

// File: tb/tb_dma_cmd_loader.sv
// Directed bench for dma_cmd_loader: table of header/word scenarios plus
// hand sequences for stalls, aborts, sticky errors and mid-commit reset.
module tb_dma_cmd_loader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hdr_valid, word_valid, cmd_done, cmd_error, err_clr, reg_wr_ready;
  logic [31:0] link_header, word_data;
  logic        reg_wr_en, load_done, busy, ldr_err;
  logic [4:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [1:0]  ldr_err_code;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;

  logic [4:0]  wq_idx [$];
  logic [31:0] wq_dat [$];
  int          wq_cyc [$];
  int          ld_cnt = 0;
  int          ld_cyc = -1;

  always #5 clk = ~clk;

  dma_cmd_loader dut (
    .clk(clk), .resetn(resetn), .hdr_valid(hdr_valid), .link_header(link_header),
    .word_valid(word_valid), .word_data(word_data), .cmd_done(cmd_done),
    .cmd_error(cmd_error), .err_clr(err_clr), .reg_wr_en(reg_wr_en),
    .reg_wr_ready(reg_wr_ready), .reg_wr_idx(reg_wr_idx), .reg_wr_data(reg_wr_data),
    .load_done(load_done), .busy(busy), .ldr_err(ldr_err), .ldr_err_code(ldr_err_code)
  );

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Log accepted writes and load_done pulses mid-cycle.
  always @(negedge clk) begin
    if (reg_wr_en && reg_wr_ready) begin
      wq_idx.push_back(reg_wr_idx);
      wq_dat.push_back(reg_wr_data);
      wq_cyc.push_back(cyc_cnt);
    end
    if (load_done) begin
      ld_cnt <= ld_cnt + 1;
      ld_cyc <= cyc_cnt;
    end
  end

  typedef struct {
    logic [31:0]     hdr;
    int              nwords;
    bit              done;
    logic [1:0]      code;
    int              nwr;
    logic [2:0][4:0] idx;
    int              ld;
  } vec_t;

  vec_t vecs [5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_hdr(input logic [31:0] h);
    hdr_valid = 1'b1; link_header = h; cyc(); hdr_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    word_valid = 1'b1; word_data = d; cyc(); word_valid = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    chk("err_clr_flag", 32'(ldr_err), 32'd0);
    chk("err_clr_code", 32'(ldr_err_code), 32'd0);
  endtask

  function automatic logic [31:0] wdat(input int v, input int k);
    return 32'hD000_0000 + 32'(v * 256 + k);
  endfunction

  task automatic run_vec(input int v);
    int wb, lb, t_hdr, t_done;
    wb = wq_idx.size();
    lb = ld_cnt;
    t_done = 0;
    send_hdr(vecs[v].hdr);
    t_hdr = cyc_cnt;
    for (int k = 0; k < vecs[v].nwords; k++) send_word(wdat(v, k));
    if (vecs[v].done) begin
      cmd_done = 1'b1; cyc(); cmd_done = 1'b0;
      t_done = cyc_cnt;
    end
    wait_idle();
    cyc(); cyc();
    chk($sformatf("v%0d_nwr", v), 32'(wq_idx.size() - wb), 32'(vecs[v].nwr));
    for (int k = 0; k < vecs[v].nwr && wb + k < wq_idx.size(); k++) begin
      chk($sformatf("v%0d_idx%0d", v, k), 32'(wq_idx[wb+k]), 32'(vecs[v].idx[k]));
      chk($sformatf("v%0d_dat%0d", v, k), wq_dat[wb+k], wdat(v, k));
      chk($sformatf("v%0d_wcyc%0d", v, k), 32'(wq_cyc[wb+k]), 32'(t_done + k));
    end
    chk($sformatf("v%0d_ld", v), 32'(ld_cnt - lb), 32'(vecs[v].ld));
    if (vecs[v].ld == 1)
      chk($sformatf("v%0d_ldcyc", v), 32'(ld_cyc),
          32'((vecs[v].nwr == 0) ? t_hdr : t_done + vecs[v].nwr));
    chk($sformatf("v%0d_err", v), 32'(ldr_err), 32'(vecs[v].code != 2'b00));
    chk($sformatf("v%0d_code", v), 32'(ldr_err_code), 32'(vecs[v].code));
    clear_err();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, lb;
    vecs[0] = '{32'h0000_0016, 3, 1'b1, 2'b00, 3, {5'd4, 5'd2, 5'd1}, 1};
    vecs[1] = '{32'h8000_0001, 0, 1'b0, 2'b00, 0, {5'd0, 5'd0, 5'd0}, 1};
    vecs[2] = '{32'h0000_0002, 2, 1'b1, 2'b01, 0, {5'd0, 5'd0, 5'd0}, 0};
    vecs[3] = '{32'h0000_000E, 2, 1'b1, 2'b10, 0, {5'd0, 5'd0, 5'd0}, 0};
    vecs[4] = '{32'hC000_0001, 1, 1'b1, 2'b00, 1, {5'd0, 5'd0, 5'd30}, 1};

    resetn = 1'b0; hdr_valid = 0; word_valid = 0; cmd_done = 0; cmd_error = 0;
    err_clr = 0; reg_wr_ready = 1'b1; link_header = '0; word_data = '0;
    cyc(); cyc(); cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_en", 32'(reg_wr_en), 32'd0);
    chk("rst_idx", 32'(reg_wr_idx), 32'd0);
    chk("rst_data", reg_wr_data, 32'd0);
    chk("rst_ld", 32'(load_done), 32'd0);
    chk("rst_err", 32'(ldr_err), 32'd0);
    chk("rst_code", 32'(ldr_err_code), 32'd0);
    resetn = 1'b1;
    cyc();

    for (int v = 0; v < 5; v++) run_vec(v);

    // Stall: first write held while the register file is not ready.
    wb = wq_idx.size(); lb = ld_cnt;
    reg_wr_ready = 1'b0;
    send_hdr(32'h0000_0006);
    send_word(32'h1111_0001);
    send_word(32'h2222_0002);
    cmd_done = 1'b1; cyc(); cmd_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall_en%0d", i), 32'(reg_wr_en), 32'd1);
      chk($sformatf("stall_idx%0d", i), 32'(reg_wr_idx), 32'd1);
      chk($sformatf("stall_dat%0d", i), reg_wr_data, 32'h1111_0001);
      cyc();
    end
    reg_wr_ready = 1'b1;
    wait_idle(); cyc(); cyc();
    chk("stall_nwr", 32'(wq_idx.size() - wb), 32'd2);
    if (wq_idx.size() - wb == 2) begin
      chk("stall_w0", {wq_dat[wb][26:0], wq_idx[wb]}, {27'(32'h1111_0001), 5'd1});
      chk("stall_w1", {wq_dat[wb+1][26:0], wq_idx[wb+1]}, {27'(32'h2222_0002), 5'd2});
    end
    chk("stall_ld", 32'(ld_cnt - lb), 32'd1);

    // Abort during COLLECT.
    wb = wq_idx.size(); lb = ld_cnt;
    send_hdr(32'h0000_0006);
    send_word(32'h3333_0001);
    cmd_error = 1'b1; cyc(); cmd_error = 1'b0;
    chk("abc_busy", 32'(busy), 32'd0);
    chk("abc_code", 32'(ldr_err_code), 32'd3);
    cyc(); cyc();
    chk("abc_nwr", 32'(wq_idx.size() - wb), 32'd0);
    chk("abc_ld", 32'(ld_cnt - lb), 32'd0);
    clear_err();

    // Abort after one accepted commit write.
    wb = wq_idx.size(); lb = ld_cnt;
    send_hdr(32'h0000_0006);
    send_word(32'h4444_0001);
    send_word(32'h4444_0002);
    cmd_done = 1'b1; cyc(); cmd_done = 1'b0;
    cyc();
    chk("abm_idx2", 32'(reg_wr_idx), 32'd2);
    reg_wr_ready = 1'b0; cmd_error = 1'b1; cyc(); cmd_error = 1'b0;
    chk("abm_busy", 32'(busy), 32'd0);
    chk("abm_en", 32'(reg_wr_en), 32'd0);
    chk("abm_code", 32'(ldr_err_code), 32'd3);
    cyc(); reg_wr_ready = 1'b1; cyc(); cyc();
    chk("abm_nwr", 32'(wq_idx.size() - wb), 32'd1);
    chk("abm_ld", 32'(ld_cnt - lb), 32'd0);
    clear_err();

    // Sticky first code, then err_clr colliding with a new error.
    send_hdr(32'h0000_0002);
    send_word(32'h5555_0001);
    send_word(32'h5555_0002);
    cyc();
    chk("sticky_ovf", 32'(ldr_err_code), 32'd1);
    send_hdr(32'h0000_000E);
    send_word(32'h5555_0003);
    send_word(32'h5555_0004);
    cmd_done = 1'b1; cyc(); cmd_done = 1'b0;
    chk("sticky_hold", 32'(ldr_err_code), 32'd1);
    send_hdr(32'h0000_000E);
    send_word(32'h5555_0005);
    send_word(32'h5555_0006);
    cmd_done = 1'b1; err_clr = 1'b1; cyc(); cmd_done = 1'b0; err_clr = 1'b0;
    chk("clr_new_err", 32'(ldr_err), 32'd1);
    chk("clr_new_code", 32'(ldr_err_code), 32'd2);

    // Header accepted while ldr_err is set, then reset mid-COMMIT.
    wb = wq_idx.size(); lb = ld_cnt;
    reg_wr_ready = 1'b0;
    send_hdr(32'h0000_0006);
    send_word(32'h6666_0001);
    send_word(32'h6666_0002);
    cmd_done = 1'b1; cyc(); cmd_done = 1'b0;
    chk("mrst_en_pre", 32'(reg_wr_en), 32'd1);
    resetn = 1'b0; cyc();
    chk("mrst_en", 32'(reg_wr_en), 32'd0);
    chk("mrst_idx", 32'(reg_wr_idx), 32'd0);
    chk("mrst_data", reg_wr_data, 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_err", 32'(ldr_err), 32'd0);
    chk("mrst_code", 32'(ldr_err_code), 32'd0);
    resetn = 1'b1; reg_wr_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("mrst_nwr", 32'(wq_idx.size() - wb), 32'd0);
    chk("mrst_ld", 32'(ld_cnt - lb), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
